// File: rtl/compute_tile_pkg.sv
// Shared compute_tile defaults: operand word width, bank depth and pointer sizing.
package compute_tile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

    // Pointer width for a bank of the given depth; depth is at least 2, so this is at least 1.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mux2x16.sv
// Two-input word multiplexer; s=0 selects in0, s=1 selects in1.
module mux2x16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? in1 : in0;

endmodule

// File: rtl/operand_pingpong.sv
// Two-bank ping-pong operand buffer: the producer fills one bank while the consumer drains
// the other, and a bank only changes hands once it is completely written or completely read.
module operand_pingpong
    import compute_tile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic [1:0]       bank_full
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wbank;
    logic             rbank;
    logic [1:0]       bank_full_next;

    logic             wr_fire;
    logic             rd_fire;
    logic             wr_wrap;
    logic             rd_wrap;
    logic [WIDTH-1:0] bank0_word;
    logic [WIDTH-1:0] bank1_word;

    // Handshake readiness comes from registered flags only, so nothing loops back from rd_ready.
    assign wr_ready = !bank_full[wbank];
    assign rd_valid = bank_full[rbank];
    assign rd_last  = rd_valid && (rptr == LAST_PTR);

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;
    assign wr_wrap = wr_fire && (wptr == LAST_PTR);
    assign rd_wrap = rd_fire && (rptr == LAST_PTR);

    assign bank0_word = mem[0][rptr];
    assign bank1_word = mem[1][rptr];

    mux2x16 #(
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .in0 (bank0_word),
        .in1 (bank1_word),
        .s   (rbank),
        .y   (rd_data)
    );

    // A write can only target a non-full bank and a read only a full one, so set and clear
    // never hit the same bit in one cycle.
    always_comb begin
        bank_full_next = bank_full;
        if (wr_wrap) begin
            bank_full_next[wbank] = 1'b1;
        end
        if (rd_wrap) begin
            bank_full_next[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            bank_full <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < int'(DEPTH); w++) begin
                    mem[b][w] <= '0;
                end
            end
        end else begin
            if (wr_fire) begin
                mem[wbank][wptr] <= wr_data;
                if (wr_wrap) begin
                    wptr  <= '0;
                    wbank <= !wbank;
                end else begin
                    wptr <= wptr + PTR_W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_wrap) begin
                    rptr  <= '0;
                    rbank <= !rbank;
                end else begin
                    rptr <= rptr + PTR_W'(1);
                end
            end
            bank_full <= bank_full_next;
        end
    end

endmodule

// File: tb/tb_operand_pingpong.sv
// Self-checking bench for operand_pingpong against a word-count/queue reference model.
module tb_operand_pingpong;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready = 1'b0;
    logic             rd_last;
    logic [1:0]       bank_full;

    int tests = 0;
    int fails = 0;

    // Reference model: total accepted writes/reads and the words still owed to the consumer.
    int               wcount = 0;
    int               rcount = 0;
    logic [WIDTH-1:0] q[$];

    operand_pingpong #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    // Banks completely written minus banks completely read.
    function automatic int full_banks();
        return wcount / DEPTH - rcount / DEPTH;
    endfunction

    function automatic logic [1:0] exp_bank_full();
        logic [1:0] b = 2'b00;
        for (int k = rcount / DEPTH; k < wcount / DEPTH; k++) b[k % 2] = 1'b1;
        return b;
    endfunction

    function automatic logic exp_wr_ready();
        return full_banks() < 2;
    endfunction

    function automatic logic exp_rd_valid();
        return full_banks() > 0;
    endfunction

    function automatic logic exp_rd_last();
        return exp_rd_valid() && (rcount % DEPTH == DEPTH - 1);
    endfunction

    // Drive one cycle of inputs, advance past the edge, and update the model.
    task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr,
                        output logic wf, output logic rf);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        wf = wv && exp_wr_ready();
        rf = rr && exp_rd_valid();
        @(posedge clk);
        #1;
        if (wf) begin
            q.push_back(wd);
            wcount++;
        end
        if (rf) begin
            void'(q.pop_front());
            rcount++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'hdead;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wcount = 0;
        rcount = 0;
        q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (wr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
        end
        tests++;
        if (rd_last !== 1'b0) begin
            fails++; $display("FAIL reset_rd_last: got %b want 0", rd_last);
        end
        tests++;
        if (rd_data !== 16'h0000) begin
            fails++; $display("FAIL reset_rd_data: got %h want 0000", rd_data);
        end
        tests++;
        if (bank_full !== 2'b00) begin
            fails++; $display("FAIL reset_bank_full: got %b want 00", bank_full);
        end
    endtask

    task automatic test_fill();
        logic wf, rf;
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, wf, rf);
        tests++;
        if (bank_full !== 2'b01) begin
            fails++; $display("FAIL fill0_bank_full: got %b want 01", bank_full);
        end
        tests++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b1) begin
            fails++; $display("FAIL fill0_handshake: got wr_ready=%b rd_valid=%b want 1 1",
                              wr_ready, rd_valid);
        end
        tests++;
        if (rd_data !== 16'h0001) begin
            fails++; $display("FAIL fill0_rd_data: got %h want 0001", rd_data);
        end
        for (int i = 5; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0, wf, rf);
        tests++;
        if (bank_full !== 2'b11 || wr_ready !== 1'b0) begin
            fails++; $display("FAIL fill1_full: got bank_full=%b wr_ready=%b want 11 0",
                              bank_full, wr_ready);
        end
        step(1'b1, 16'h0009, 1'b0, wf, rf);
        tests++;
        if (bank_full !== 2'b11 || wr_ready !== 1'b0 || rd_data !== 16'h0001) begin
            fails++; $display("FAIL overfill: got bank_full=%b wr_ready=%b rd_data=%h want 11 0 0001",
                              bank_full, wr_ready, rd_data);
        end
    endtask

    task automatic test_drain();
        logic wf, rf;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_data !== WIDTH'(i + 1) || rd_last !== (i == 3)) begin
                fails++; $display("FAIL drain_word%0d: got data=%h last=%b want %h %b",
                                  i, rd_data, rd_last, WIDTH'(i + 1), (i == 3));
            end
            if (i == 3) begin
                tests++;
                if (wr_ready !== 1'b0) begin
                    fails++; $display("FAIL drain_early_ready: got %b want 0", wr_ready);
                end
            end
            step(1'b0, '0, 1'b1, wf, rf);
        end
        tests++;
        if (bank_full !== 2'b10 || wr_ready !== 1'b1 || rd_data !== 16'h0005) begin
            fails++; $display("FAIL drain_swap: got bank_full=%b wr_ready=%b rd_data=%h want 10 1 0005",
                              bank_full, wr_ready, rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_data !== q[0]) begin
                fails++; $display("FAIL drain_bank1: got %h want %h", rd_data, q[0]);
            end
            step(1'b0, '0, 1'b1, wf, rf);
        end
        tests++;
        if (rd_valid !== 1'b0 || bank_full !== 2'b00) begin
            fails++; $display("FAIL drain_empty: got rd_valid=%b bank_full=%b want 0 00",
                              rd_valid, bank_full);
        end
    endtask

    task automatic test_stream();
        logic wf, rf;
        int widx = 0;
        int ridx = 0;
        int cyc = 0;
        while ((widx < 16 || ridx < 16) && cyc < 200) begin
            if (rd_valid) begin
                tests++;
                if (rd_data !== WIDTH'(16'h0100 + ridx)) begin
                    fails++; $display("FAIL stream_word%0d: got %h want %h",
                                      ridx, rd_data, WIDTH'(16'h0100 + ridx));
                end
            end
            step(widx < 16, WIDTH'(16'h0100 + widx), 1'b1, wf, rf);
            if (wf) widx++;
            if (rf) ridx++;
            cyc++;
        end
        tests++;
        if (ridx != 16 || rd_valid !== 1'b0) begin
            fails++; $display("FAIL stream_count: got %0d words rd_valid=%b want 16 0",
                              ridx, rd_valid);
        end
    endtask

    task automatic test_stall();
        logic wf, rf;
        logic [WIDTH-1:0] held;
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h0020 + i), 1'b0, wf, rf);
        for (int i = 0; i < 8; i++) begin
            held = rd_data;
            step(1'b0, '0, (i % 2 == 0), wf, rf);
            if (i % 2 == 1) begin
                tests++;
                if (rd_data !== held) begin
                    fails++; $display("FAIL stall_hold%0d: got %h want %h", i, rd_data, held);
                end
            end
            if (rd_valid) begin
                tests++;
                if (rd_data !== q[0]) begin
                    fails++; $display("FAIL stall_word%0d: got %h want %h", i, rd_data, q[0]);
                end
            end
        end
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL stall_empty: got %b want 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic wf, rf;
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(16'h0a00 + i), 1'b0, wf, rf);
        apply_reset();
        tests++;
        if (bank_full !== 2'b00 || rd_valid !== 1'b0 || rd_data !== 16'h0000 || wr_ready !== 1'b1)
        begin
            fails++; $display("FAIL reset_mid: got bank_full=%b rd_valid=%b rd_data=%h wr_ready=%b want 00 0 0000 1",
                              bank_full, rd_valid, rd_data, wr_ready);
        end
        // Old bank-0 data must be gone: a fresh fill has to read back its own words.
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h0b00 + i), 1'b0, wf, rf);
        tests++;
        if (rd_data !== 16'h0b00) begin
            fails++; $display("FAIL reset_mid_refill: got %h want 0b00", rd_data);
        end
    endtask

    task automatic test_random();
        logic wf, rf;
        for (int c = 0; c < 400; c++) begin
            tests++;
            if (wr_ready !== exp_wr_ready() || rd_valid !== exp_rd_valid() ||
                rd_last !== exp_rd_last() || bank_full !== exp_bank_full()) begin
                fails++; $display("FAIL random_ctrl@%0d: got wr_ready=%b rd_valid=%b rd_last=%b bank_full=%b want %b %b %b %b",
                                  c, wr_ready, rd_valid, rd_last, bank_full, exp_wr_ready(),
                                  exp_rd_valid(), exp_rd_last(), exp_bank_full());
            end
            if (exp_rd_valid()) begin
                tests++;
                if (rd_data !== q[0]) begin
                    fails++; $display("FAIL random_data@%0d: got %h want %h", c, rd_data, q[0]);
                end
            end
            step($urandom_range(0, 99) < 60, WIDTH'($urandom), $urandom_range(0, 99) < 50, wf, rf);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_pingpong.md
OPERAND_PINGPONG -- requirements
Module: operand_pingpong

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, words per bank, a power of two, 2 or greater.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 wr_valid  input  1  the producer offers wr_data.
REQ-006 wr_data  input  WIDTH  operand word to store.
REQ-007 wr_ready  output  1  the block accepts wr_data this cycle.
REQ-008 rd_valid  output  1  rd_data holds a valid operand.
REQ-009 rd_data  output  WIDTH  current operand from the read bank.
REQ-010 rd_ready  input  1  the consumer takes rd_data this cycle.
REQ-011 rd_last  output  1  rd_data is the final word of the read bank.
REQ-012 bank_full  output  2  per-bank full flags; bit i is bank i.

Function
REQ-013 Storage SHALL be two banks, each DEPTH words of WIDTH bits.
REQ-014 A write SHALL be accepted when wr_valid and wr_ready are both high; the word is stored at bank[wbank][wptr], then wptr increments.
REQ-015 A write accepted at wptr==DEPTH-1 SHALL set bank_full[wbank], toggle wbank, and wrap wptr to 0 on the same edge.
REQ-016 wr_ready SHALL equal !bank_full[wbank], decoded from registered state only, with no combinational path from rd_ready.
REQ-017 rd_valid SHALL equal bank_full[rbank].
REQ-018 rd_data SHALL equal bank[rbank][rptr], selected combinationally with zero latency.
REQ-019 rd_last SHALL equal rd_valid && (rptr==DEPTH-1).
REQ-020 A read SHALL be accepted when rd_valid and rd_ready are both high, and rptr then increments.
REQ-021 A read accepted at rptr==DEPTH-1 SHALL clear bank_full[rbank], toggle rbank, and wrap rptr to 0.
REQ-022 Write and read on different banks in the same cycle SHALL both complete independently.
REQ-023 A bank released by a read SHALL first show wr_ready high on the following cycle (one-cycle turnaround, no same-cycle reuse).
REQ-024 A bank filled by a write SHALL first show rd_valid high on the following cycle.
REQ-025 When both banks are full, wr_ready SHALL be low; when both are empty, rd_valid SHALL be low.
REQ-026 While wr_valid is low or wr_ready is low, storage and write state SHALL hold.
REQ-027 While rd_ready is low or rd_valid is low, read state SHALL hold and rd_data SHALL stay stable.
REQ-028 Words SHALL be delivered in strict write order across bank swaps; no word is lost or duplicated.

Reset
REQ-029 rst_n low at a clock edge SHALL force:
  - wptr=0, rptr=0, wbank=0, rbank=0;
  - bank_full=2'b00;
  - all storage to 0.
REQ-030 After reset, outputs SHALL read wr_ready=1, rd_valid=0, rd_last=0, rd_data=0.
REQ-031 Reset asserted mid-fill or mid-drain SHALL discard all partial data, and the handshake SHALL ignore wr_valid and rd_ready in that cycle.

Structure
REQ-032 Defaults for WIDTH and DEPTH, and the pointer width $clog2(DEPTH), SHALL live in the shared compute_tile package.
REQ-033 The bank select for rd_data SHALL be one mux2x16 instance: in0 from bank 0, in1 from bank 1, s=rbank.
REQ-034 Word select within a bank SHALL stay local to the block; pointers and flags SHALL be separate registers, with no FSM encoding beyond wbank and rbank.

Verification
REQ-035 Reset then write 0x0001..0x0004 with rd_ready=0 -> bank_full=01, wr_ready=1, rd_valid=1, rd_data=0x0001.
REQ-036 Continue writing 0x0005..0x0008 -> bank_full=11, wr_ready=0; a further write of 0x0009 is not accepted.
REQ-037 rd_ready=1 for 4 cycles -> rd_data is 0x0001..0x0004, rd_last is high on the fourth word only, then bank_full=10, rbank=1, and wr_ready rises one cycle later.
REQ-038 Continuous streaming of 0x0100..0x010F with rd_ready=1 throughout -> output sequence is identical and in order, with no duplicates.
REQ-039 rd_ready toggled 1,0,1,0 during a drain -> rd_data is held steady on the stalled cycles.
REQ-040 rst_n=0 after 2 writes into bank 1 while bank 0 is full -> next cycle bank_full=00, rd_valid=0, rd_data=0, wr_ready=1.
